// File: rtl/data_memory_arbiter_if.sv
// Bus bundle between the data memory arbiter, its requesters and the vector data memory.
// slave = arbiter side, master = requester/memory side.
interface data_memory_arbiter_if #(
  parameter int dataSize       = 32,
  parameter int addressingSize = 32,
  parameter int vecSize        = 4,
  parameter int numReq         = 2
);
  logic [numReq-1:0]                            req;
  logic [numReq-1:0]                            req_we;
  logic [numReq-1:0][addressingSize-1:0]        req_addr;
  logic [numReq-1:0][vecSize-1:0][dataSize-1:0] req_wdata;
  logic [numReq-1:0]                            ack;
  logic [vecSize-1:0][dataSize-1:0]             rdata;
  logic                                         busy;
  logic                                         mem_we;
  logic [addressingSize-1:0]                    mem_addr;
  logic [vecSize-1:0][dataSize-1:0]             mem_wdata;
  logic [vecSize-1:0][dataSize-1:0]             mem_rdata;

  modport slave (
    input  req, req_we, req_addr, req_wdata, mem_rdata,
    output ack, rdata, busy, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output req, req_we, req_addr, req_wdata, mem_rdata,
    input  ack, rdata, busy, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/data_memory_arbiter.sv
// Serialises numReq requesters onto the single vector data memory port (IDLE -> ISSUE -> RESP).
// DATA_MEMORY_ARBITER_RR_EN selects round-robin arbitration; otherwise lowest index wins.
//
// state | meaning
// IDLE  | sample requests, latch winner's fields into the mem_* holding registers
// ISSUE | drive mem_we/addr/wdata; memory writes or captures read data on the closing edge
// RESP  | mem_we low, address held; ack the owner and pass mem_rdata through
module data_memory_arbiter #(
  parameter int dataSize       = 32,
  parameter int addressingSize = 32,
  parameter int vecSize        = 4,
  parameter int numReq         = 2
) (
  input logic                   clk,
  input logic                   rst,
  data_memory_arbiter_if.slave  bus
);
  localparam int OW = $clog2(numReq);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t                           state, state_nxt;
  logic [OW-1:0]                    owner, last_owner, winner;
  logic                             grant_vld;
  logic                             we_q;
  logic [addressingSize-1:0]        addr_q;
  logic [vecSize-1:0][dataSize-1:0] wdata_q;

`ifdef DATA_MEMORY_ARBITER_RR_EN
  logic [OW-1:0] rr_idx;

  // Search starts just after the previous owner, wrapping at numReq.
  always_comb begin
    winner    = '0;
    grant_vld = 1'b0;
    rr_idx    = '0;
    for (int k = 1; k <= numReq; k++) begin
      rr_idx = OW'((int'(last_owner) + k) % numReq);
      if (!grant_vld && bus.req[rr_idx]) begin
        grant_vld = 1'b1;
        winner    = rr_idx;
      end
    end
  end
`else
  always_comb begin
    winner    = '0;
    grant_vld = 1'b0;
    for (int i = numReq - 1; i >= 0; i--) begin
      if (bus.req[i]) begin
        grant_vld = 1'b1;
        winner    = OW'(i);
      end
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      owner      <= '0;
      last_owner <= OW'(numReq - 1);
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && grant_vld) begin
        owner   <= winner;
        we_q    <= bus.req_we[winner];
        addr_q  <= bus.req_addr[winner];
        wdata_q <= bus.req_wdata[winner];
      end
      if (state == RESP) begin
        last_owner <= owner;
      end
    end
  end

  always_comb begin
    state_nxt  = state;
    bus.ack    = '0;
    bus.busy   = 1'b0;
    bus.mem_we = 1'b0;
    case (state)
      IDLE: begin
        if (grant_vld) begin
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        bus.busy   = 1'b1;
        bus.mem_we = we_q;
        state_nxt  = RESP;
      end
      RESP: begin
        bus.busy       = 1'b1;
        bus.ack[owner] = 1'b1;
        state_nxt      = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Address stays on the bus in RESP so the registered memory re-reads the same word.
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.rdata     = bus.mem_rdata;
endmodule

// File: tb/tb_data_memory_arbiter.sv
// Self-checking bench for data_memory_arbiter: directed scenarios plus randomized requesters,
// checked every cycle against a transaction-timeline model with its own memory image.
module tb_data_memory_arbiter;
  localparam int NR = 4;
  localparam int DS = 32;
  localparam int AS = 32;
  localparam int VS = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  data_memory_arbiter_if #(.dataSize(DS), .addressingSize(AS), .vecSize(VS), .numReq(NR)) bus ();

  data_memory_arbiter #(.dataSize(DS), .addressingSize(AS), .vecSize(VS), .numReq(NR)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [127:0] init_word(input int i);
    if (i == 1) return 128'h00000044_00000033_00000022_00000011;
    return {32'(i * 4 + 3), 32'(i * 4 + 2), 32'(i * 4 + 1), 32'(i * 4)} ^ {4{32'hA5A50000}};
  endfunction

  function automatic int aidx(input logic [AS-1:0] a);
    return int'(a[13:6]);
  endfunction

  // Memory with registered read; reloaded while reset is held so its content is known.
  logic [VS-1:0][DS-1:0] mem_store [256];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) mem_store[i] <= init_word(i);
    end else if (bus.mem_we) begin
      mem_store[aidx(bus.mem_addr)] <= bus.mem_wdata;
    end
    bus.mem_rdata <= mem_store[aidx(bus.mem_addr)];
  end

  // Reference model: one outstanding transaction, aged in cycles since its grant.
  logic [127:0]  ref_mem [256];
  logic [NR-1:0] ack_seen;
  int            m_active, m_age, m_owner, m_last, w, j;
  logic          m_we;
  logic [AS-1:0] m_addr;
  logic [127:0]  m_wdata;
  logic          idle_now;

  always @(negedge clk) begin
    ack_seen <= bus.ack;
    if (rst) begin
      for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
      m_active = 0; m_age = 0; m_last = NR - 1; m_addr = '0; m_wdata = '0; m_owner = 0; m_we = 1'b0;
      chk("rst_busy", 128'(bus.busy), 128'(0));
      chk("rst_ack", 128'(bus.ack), 128'(0));
      chk("rst_mem_we", 128'(bus.mem_we), 128'(0));
      chk("rst_mem_addr", 128'(bus.mem_addr), 128'(0));
    end else begin
      idle_now = (m_active == 0);
      if (!idle_now) begin
        m_age++;
        chk("mdl_busy", 128'(bus.busy), 128'(1));
        chk("mdl_mem_we", 128'(bus.mem_we), 128'((m_age == 1) && m_we));
        chk("mdl_ack", 128'(bus.ack), (m_age == 2) ? (128'(1) << m_owner) : 128'(0));
        if (m_age == 1) chk("mdl_mem_wdata", 128'(bus.mem_wdata), m_wdata);
        if (m_age == 2 && !m_we) chk("mdl_rdata", 128'(bus.rdata), ref_mem[aidx(m_addr)]);
        if (m_age == 2) m_active = 0;
      end else begin
        chk("mdl_idle_busy", 128'(bus.busy), 128'(0));
        chk("mdl_idle_ack", 128'(bus.ack), 128'(0));
        chk("mdl_idle_we", 128'(bus.mem_we), 128'(0));
      end
      chk("mdl_mem_addr", 128'(bus.mem_addr), 128'(m_addr));
      if (idle_now && (|bus.req)) begin
        w = -1;
`ifdef DATA_MEMORY_ARBITER_RR_EN
        for (int k = 1; k <= NR; k++) begin
          j = (m_last + k) % NR;
          if (w < 0 && bus.req[j]) w = j;
        end
`else
        for (int k = 0; k < NR; k++) if (w < 0 && bus.req[k]) w = k;
`endif
        m_active = 1; m_age = 0; m_owner = w; m_last = w;
        m_we    = bus.req_we[w];
        m_addr  = bus.req_addr[w];
        m_wdata = 128'(bus.req_wdata[w]);
        if (m_we) ref_mem[aidx(m_addr)] = m_wdata;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int p, input logic we, input logic [AS-1:0] a, input logic [127:0] d);
    bus.req[p]       = 1'b1;
    bus.req_we[p]    = we;
    bus.req_addr[p]  = a;
    bus.req_wdata[p] = d;
  endtask

  task automatic drive_rand(input int p, input logic allow_we);
    logic [127:0] d;
    d = {$urandom, $urandom, $urandom, $urandom};
    drive(p, allow_we & 1'($urandom % 2), 32'h200 + 32'($urandom_range(0, 7)) * 32'h40, d);
  endtask

  int ord[$];
  int exp_p;

  initial begin
    bus.req = '0; bus.req_we = '0; bus.req_addr = '0; bus.req_wdata = '0;
    repeat (3) step();
    rst = 1'b0;

    // Single read of the preloaded word.
    drive(0, 1'b0, 32'h40, '0);
    @(negedge clk); chk("t1_idle_busy", 128'(bus.busy), 128'(0));
    @(negedge clk); chk("t1_issue_busy", 128'(bus.busy), 128'(1));
    chk("t1_issue_we", 128'(bus.mem_we), 128'(0));
    @(negedge clk); chk("t1_ack", 128'(bus.ack), 128'h1);
    chk("t1_rdata", 128'(bus.rdata), 128'h00000044_00000033_00000022_00000011);
    step(); bus.req[0] = 1'b0;

    // Write then read back on port 1.
    drive(1, 1'b1, 32'h80, 128'h0000000D_0000000C_0000000B_0000000A);
    @(negedge clk); chk("t1_busy_after", 128'(bus.busy), 128'(0));
    @(negedge clk); chk("t2_we", 128'(bus.mem_we), 128'(1));
    chk("t2_addr", 128'(bus.mem_addr), 128'h80);
    @(negedge clk); chk("t2_we_resp", 128'(bus.mem_we), 128'(0));
    chk("t2_wack", 128'(bus.ack), 128'h2);
    step(); drive(1, 1'b0, 32'h80, '0);
    repeat (3) @(negedge clk);
    chk("t2_rack", 128'(bus.ack), 128'h2);
    chk("t2_rdata", 128'(bus.rdata), 128'h0000000D_0000000C_0000000B_0000000A);
    step(); bus.req[1] = 1'b0;

    // Contention between ports 0 and 1 for 12 cycles.
    drive_rand(0, 1'b0); drive_rand(1, 1'b0);
    ord.delete();
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      for (int p = 0; p < NR; p++) if (bus.ack[p]) ord.push_back(p);
      step();
      if (i == 11) bus.req = '0;
      else for (int p = 0; p < 2; p++) if (ack_seen[p]) drive_rand(p, 1'b0);
    end
    chk("t3_count", 128'(ord.size()), 128'(4));
    for (int i = 0; i < ord.size(); i++) begin
`ifdef DATA_MEMORY_ARBITER_RR_EN
      exp_p = i % 2;
`else
      exp_p = 0;
`endif
      chk("t3_order", 128'(ord[i]), 128'(exp_p));
    end

    // Reset while a write to 0x100 is in ISSUE.
    drive(0, 1'b1, 32'h100, {4{32'hDEADBEEF}});
    @(negedge clk);
    @(negedge clk); chk("t4_issue_we", 128'(bus.mem_we), 128'(1));
    #2 rst = 1'b1;
    #1;
    chk("t4_we_async", 128'(bus.mem_we), 128'(0));
    chk("t4_busy_async", 128'(bus.busy), 128'(0));
    chk("t4_ack_async", 128'(bus.ack), 128'(0));
    bus.req = '0;
    step(); step();
    rst = 1'b0;

    // All four ports requesting continuously.
    for (int p = 0; p < NR; p++) drive_rand(p, 1'b0);
    ord.delete();
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      for (int p = 0; p < NR; p++) if (bus.ack[p]) ord.push_back(p);
      step();
      if (i == 23) bus.req = '0;
      else for (int p = 0; p < NR; p++) if (ack_seen[p]) drive_rand(p, 1'b0);
    end
    chk("t6_count", 128'(ord.size()), 128'(8));
    for (int i = 0; i < ord.size(); i++) begin
`ifdef DATA_MEMORY_ARBITER_RR_EN
      exp_p = i % NR;
`else
      exp_p = 0;
`endif
      chk("t6_order", 128'(ord[i]), 128'(exp_p));
    end

    // Port 1 requests during port 0's ISSUE and withdraws before IDLE.
    drive(0, 1'b0, 32'h40, '0);
    @(negedge clk); step();
    drive(1, 1'b0, 32'h2C0, '0);
    @(negedge clk); step();
    bus.req[1] = 1'b0;
    @(negedge clk); chk("t5_ack0", 128'(bus.ack), 128'h1);
    step(); bus.req[0] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t5_no_ack", 128'(bus.ack), 128'(0));
      chk("t5_addr_held", 128'(bus.mem_addr), 128'h40);
    end

    // Randomized requesters.
    for (int c = 0; c < 600; c++) begin
      step();
      for (int p = 0; p < NR; p++) begin
        if (bus.req[p]) begin
          if (ack_seen[p]) begin
            if ($urandom % 2 == 0) drive_rand(p, 1'b1);
            else bus.req[p] = 1'b0;
          end
        end else if ($urandom % 4 == 0) begin
          drive_rand(p, 1'b1);
        end
      end
    end
    step(); bus.req = '0;
    repeat (5) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/data_memory_arbiter.md
Name: data_memory_arbiter

Overview:
- Shares the single vector data memory port between `numReq` requesters: vector LSU, host loader and config/debug.
- Serialises requests through a 3-state FSM, drives the memory's clk-domain control (we/addr/wdata) and returns read data with a per-requester ack.
- Sits between the requesters and the data memory instance in the ASIP top level.

Parameters:
- dataSize, 32, bits per vector lane
- addressingSize, 32, address width
- vecSize, 4, lanes per access
- numReq, 2, number of requesters (2..8)

Ports:
- clk  in  1  system clock, all logic on posedge
- rst  in  1  asynchronous, active-high reset
- req  in  numReq  per-requester request, held high until ack
- req_we  in  [numReq-1:0]  1 = write, 0 = read
- req_addr  in  [numReq-1:0][addressingSize-1:0]  access address
- req_wdata  in  [numReq-1:0][vecSize-1:0][dataSize-1:0]  write vector
- ack  out  numReq  one-cycle completion pulse to the owner
- rdata  out  [vecSize-1:0][dataSize-1:0]  read vector; valid only with ack of a read
- busy  out  1  high in ISSUE and RESP
- mem_we  out  1  to memory write_enable
- mem_addr  out  addressingSize  to memory DataAdr
- mem_wdata  out  [vecSize-1:0][dataSize-1:0]  to memory toWrite_data
- mem_rdata  in  [vecSize-1:0][dataSize-1:0]  from memory read_data (registered in memory, 1-cycle latency)

Behaviour:
- Reset (async, immediate) drives the following:
  - state=IDLE
  - owner=0
  - last_owner=numReq-1
  - mem_we=0, mem_addr=0, mem_wdata=0
  - ack=0, busy=0
  - rdata follows mem_rdata and has no reset value.
- FSM states: IDLE, ISSUE, RESP. Every transaction takes exactly 3 cycles: IDLE(sample) → ISSUE → RESP.
- IDLE:
  - If any req is high, select a winner per the arbitration rule.
  - Register owner, req_we, req_addr and req_wdata of the winner into mem_* holding registers (we held internally).
  - Next state is ISSUE.
  - If no req is high, stay in IDLE with all mem_* registers unchanged.
- ISSUE:
  - mem_we = latched we; mem_addr and mem_wdata come from the registers.
  - Memory performs the write, or captures read data, on the edge ending ISSUE.
  - Next state is RESP.
- RESP:
  - mem_we=0; mem_addr is still held, so the memory re-reads the same address and data stays stable.
  - ack[owner]=1 for both reads and writes; rdata=mem_rdata.
  - If owner issued a write, rdata content is don't-care.
  - Update last_owner=owner. Next state is IDLE.
- mem_we is high only in ISSUE, at most 1 cycle per transaction. No two transactions overlap. busy=1 in ISSUE and RESP.
- Requester rules:
  - Hold req, we, addr and wdata stable from raise until ack.
  - Drop req, or present a new request, from the cycle after ack.
  - The arbiter samples requester fields only in IDLE, so changes in ISSUE/RESP are ignored.
- Requests arriving during ISSUE/RESP wait. Back-to-back throughput is one transaction per 3 cycles.
- Simultaneous requests: exactly one winner per IDLE. Losers stay pending and get no ack.
- A req dropped before ack while not yet granted is legal; the request is simply withdrawn.
- Reset mid-transaction:
  - Abort, with no ack.
  - If reset is asserted during ISSUE, mem_we falls immediately. A write is not guaranteed to complete; the bench must not rely on it.
- Addresses pass through unmodified, with no alignment check.

Optional Feature:
- Macro DATA_MEMORY_ARBITER_RR_EN.
- Defined: round-robin. Search starts at (last_owner+1) mod numReq and takes the first high req. Since last_owner resets to numReq-1, port 0 wins first after reset.
- Undefined: fixed priority, lowest index wins. last_owner is still updated but unused.

Test Plan:
1. Single read: port0 reads addr 0x40 (memory preloaded lanes 0x11,0x22,0x33,0x44) → mem_we stays 0; ack[0] exactly 3 cycles after req rises; rdata = {0x44,0x33,0x22,0x11}; busy high for 2 cycles.
2. Write then read: port1 writes {0xA,0xB,0xC,0xD} to 0x80, then reads 0x80 → mem_we high exactly 1 cycle (ISSUE) with mem_addr=0x80; second ack returns {0xD,0xC,0xB,0xA}.
3. Contention: ports 0 and 1 raise req in the same cycle and hold until acked, repeated ×4. With RR_EN, ack order is 0,1,0,1,…; without RR_EN, port0 continuously re-requesting causes port1 to starve (no ack[1] in 12 cycles).
4. Reset in ISSUE of a write to 0x100 → mem_we drops asynchronously; state IDLE; no ack; busy=0 immediately.
5. Req withdrawn: port1 raises req during port0's ISSUE and drops it before IDLE → no transaction for port1; mem_addr unchanged; no ack[1].
6. numReq=4, all four requesting continuously with RR_EN → grants rotate 0,1,2,3,0; each port acked once per 12 cycles.
